fetch_stage: RTL and testbench

//  Instruction fetch stage plus IF/ID pipeline register for the 32-bit RISC-V core.

---
 rtl/fetch_stage.sv | 143 ++++++++++++++
 tb/tb_fetch_stage.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register and single-outstanding imem handshake.
// Optional performance counters enabled by defining IF_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_valid,
   input  logic        stall_id,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        ifid_valid,
   output logic [31:0] ifid_pc,
   output logic [31:0] ifid_instr,
   output logic [6:0]  ifid_opcode
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_DROP
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_drop_addr;
   logic [31:0] r_skid;
   logic [31:0] r_skid_pc;
   logic        r_ifid_valid;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_instr;

   logic [31:0] w_pc_inc;
   logic [31:0] w_redir_pc;
   logic [31:0] w_reset_pc;
   logic        w_load;

   assign w_pc_inc   = r_pc + 32'd4;
   assign w_redir_pc = redirect_pc & 32'hFFFF_FFFC;
   assign w_reset_pc = RESET_PC & 32'hFFFF_FFFC;

   // IF/ID receives a real instruction on this edge
   assign w_load = !reset && !redirect_valid && !stall_id &&
                   ((r_state == S_FETCH && imem_valid) ||
                    r_state == S_HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_pc         <= w_reset_pc;
         r_drop_addr  <= 32'd0;
         r_skid       <= NOP_INSTR;
         r_skid_pc    <= 32'd0;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= 32'd0;
         r_ifid_instr <= NOP_INSTR;
      end else if (redirect_valid) begin
         r_pc         <= w_redir_pc;
         r_ifid_valid <= 1'b0;
         r_skid       <= NOP_INSTR;
         unique case (r_state)
            S_FETCH: begin
               // unanswered request must complete at its old address
               if (!imem_valid) begin
                  r_state     <= S_DROP;
                  r_drop_addr <= r_pc;
               end
            end
            S_HOLD: r_state <= S_FETCH;
            default: begin
               if (imem_valid) r_state <= S_FETCH;
            end
         endcase
      end else begin
         unique case (r_state)
            S_FETCH: begin
               if (imem_valid) begin
                  r_pc <= w_pc_inc;
                  if (stall_id) begin
                     r_skid    <= imem_rdata;
                     r_skid_pc <= r_pc;
                     r_state   <= S_HOLD;
                  end else begin
                     r_ifid_valid <= 1'b1;
                     r_ifid_pc    <= r_pc;
                     r_ifid_instr <= imem_rdata;
                  end
               end else if (!stall_id) begin
                  r_ifid_valid <= 1'b0;
               end
            end
            S_HOLD: begin
               if (!stall_id) begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_pc    <= r_skid_pc;
                  r_ifid_instr <= r_skid;
                  r_state      <= S_FETCH;
               end
            end
            default: begin
               r_ifid_valid <= 1'b0;
               if (imem_valid) r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign imem_req    = !reset && (r_state != S_HOLD);
   assign imem_addr   = (r_state == S_DROP) ? r_drop_addr : r_pc;
   assign ifid_valid  = r_ifid_valid;
   assign ifid_pc     = r_ifid_pc;
   assign ifid_instr  = r_ifid_valid ? r_ifid_instr : NOP_INSTR;
   assign ifid_opcode = r_ifid_valid ? r_ifid_instr[6:0] : 7'b0;

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_bubble_cnt;

   // a bubble is an edge where decode is ready but IF/ID gets no instruction
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_cnt  <= 32'd0;
         r_bubble_cnt <= 32'd0;
      end else begin
         if (w_load) r_fetch_cnt <= r_fetch_cnt + 32'd1;
         if (!stall_id && !w_load) r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
   end

   assign perf_fetch_cnt  = r_fetch_cnt;
   assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based behavioural model.
// Memory model answers with random latency; stall, redirect and reset are random.
module tb_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_valid;
   logic        stall_id;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic [6:0]  ifid_opcode;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_bubble_cnt;
`endif

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC (RST_PC),
      .NOP_INSTR(NOP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .imem_valid    (imem_valid),
      .stall_id      (stall_id),
      .redirect_valid(redirect_valid),
      .redirect_pc   (redirect_pc),
      .ifid_valid    (ifid_valid),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr),
      .ifid_opcode   (ifid_opcode)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } slot_t;

   // words fetched while decode was stalled, waiting to enter IF/ID
   slot_t       park[$];
   logic [31:0] m_pc;
   logic [31:0] m_stale_addr;
   bit          m_stale;
   bit          m_v;
   logic [31:0] m_ipc;
   logic [31:0] m_instr;
   logic [31:0] m_fcnt;
   logic [31:0] m_bcnt;

   bit          mem_busy;
   logic [31:0] mem_addr;
   int          mem_wait;
   int          max_lat, p_stall, p_redir, p_rst;

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   function automatic bit exp_req();
      return !reset && park.size() == 0;
   endfunction

   function automatic logic [31:0] exp_addr();
      return m_stale ? m_stale_addr : m_pc;
   endfunction

   task automatic mem_respond();
      imem_valid = 1'b0;
      imem_rdata = $urandom;
      if (exp_req()) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_addr = exp_addr();
            mem_wait = $urandom_range(max_lat);
         end
         if (mem_wait == 0) begin
            imem_valid = 1'b1;
            imem_rdata = word_at(mem_addr);
         end else begin
            mem_wait--;
         end
      end
   endtask

   task automatic drive();
      reset          = ($urandom_range(99) < p_rst);
      stall_id       = ($urandom_range(99) < p_stall);
      redirect_valid = ($urandom_range(99) < p_redir);
      if ($urandom_range(3) == 0)
         redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
      else
         redirect_pc = $urandom;
      mem_respond();
   endtask

   task automatic model_edge();
      bit    t;
      bit    ld;
      slot_t s;
      t  = exp_req() && imem_valid;
      ld = 1'b0;
      if (t) mem_busy = 1'b0;
      if (reset) begin
         m_pc     = RST_PC;
         m_stale  = 1'b0;
         park.delete();
         m_v      = 1'b0;
         m_ipc    = 32'd0;
         m_instr  = NOP;
         mem_busy = 1'b0;
         m_fcnt   = 32'd0;
         m_bcnt   = 32'd0;
      end else begin
         if (redirect_valid) begin
            if (!m_stale && exp_req() && !t) begin
               m_stale      = 1'b1;
               m_stale_addr = m_pc;
            end else if (t) begin
               m_stale = 1'b0;
            end
            m_pc = redirect_pc & 32'hFFFF_FFFC;
            park.delete();
            m_v = 1'b0;
         end else if (m_stale) begin
            m_v = 1'b0;
            if (t) m_stale = 1'b0;
         end else if (park.size() != 0) begin
            if (!stall_id) begin
               s = park.pop_front();
               m_v = 1'b1; m_ipc = s.pc; m_instr = s.instr; ld = 1'b1;
            end
         end else if (t) begin
            if (stall_id) begin
               park.push_back('{pc: m_pc, instr: imem_rdata});
            end else begin
               m_v = 1'b1; m_ipc = m_pc; m_instr = imem_rdata; ld = 1'b1;
            end
            m_pc = m_pc + 32'd4;
         end else if (!stall_id) begin
            m_v = 1'b0;
         end
         if (ld) m_fcnt = m_fcnt + 32'd1;
         if (!stall_id && !m_v) m_bcnt = m_bcnt + 32'd1;
      end
   endtask

   task automatic compare();
      logic [31:0] ei;
      ei = m_v ? m_instr : NOP;
      chk("imem_req", 32'(imem_req), 32'(exp_req()));
      chk("imem_addr", imem_addr, exp_addr());
      chk("ifid_valid", 32'(ifid_valid), 32'(m_v));
      chk("ifid_pc", ifid_pc, m_ipc);
      chk("ifid_instr", ifid_instr, ei);
      chk("ifid_opcode", 32'(ifid_opcode), m_v ? 32'(ei[6:0]) : 32'd0);
`ifdef IF_PERF_CNT_EN
      chk("perf_fetch", perf_fetch_cnt, m_fcnt);
      chk("perf_bubble", perf_bubble_cnt, m_bcnt);
`endif
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare();
   endtask

   task automatic phase(input int lat, input int ps, input int pr,
                        input int prst, input int n);
      max_lat = lat; p_stall = ps; p_redir = pr; p_rst = prst;
      repeat (n) begin
         drive();
         step();
      end
   endtask

   initial begin
      reset = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0;
      redirect_pc = 32'd0; imem_valid = 1'b0; imem_rdata = 32'd0;
      m_pc = RST_PC; m_stale = 1'b0; m_stale_addr = 32'd0; m_v = 1'b0;
      m_ipc = 32'd0; m_instr = NOP; m_fcnt = 32'd0; m_bcnt = 32'd0;
      mem_busy = 1'b0; mem_addr = 32'd0; mem_wait = 0; max_lat = 0;
      @(negedge clk);
      step();
      step();

      // zero-wait memory, no stalls: one instruction per cycle
      max_lat = 0; p_stall = 0; p_redir = 0; p_rst = 0;
      for (int i = 0; i < 3; i++) begin
         drive();
         chk("seq_addr", imem_addr, RST_PC + 32'(4 * i));
         step();
         if (i > 0) chk("seq_ifid_pc", ifid_pc, RST_PC + 32'(4 * i));
      end
      phase(0, 0, 0, 0, 30);
      phase(0, 30, 0, 0, 200);
      phase(0, 20, 25, 0, 300);
      phase(3, 25, 15, 0, 400);
      phase(3, 40, 15, 3, 400);
      phase(2, 10, 5, 1, 300);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
